// File: rtl/irq_pkg.sv
// Shared constants for the IRQ pending controller: default sizing and FSM state codes.
package irq_pkg;
    localparam int unsigned N    = 8;
    localparam int unsigned IDXW = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;
endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: index of the highest set bit plus an any flag.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int unsigned N    = irq_pkg::N,
    parameter int unsigned IDXW = irq_pkg::IDXW
) (
    input  logic [N-1:0]    vec_i,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    // Ascending scan so the last hit, the highest bit, wins.
    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o = i[IDXW-1:0];
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-detecting IRQ pending register with a valid/ready offer of the highest-priority bit.
// Optional IRQ_MASK_EN adds an irq_mask input gating which pending bits may be offered.
module irq_pending_ctrl #(
    parameter int unsigned N    = irq_pkg::N,
    parameter int unsigned IDXW = irq_pkg::IDXW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic            irq_ready,
`ifdef IRQ_MASK_EN
    input  logic [N-1:0]    irq_mask,
`endif
    output logic            irq_valid,
    output logic [IDXW-1:0] irq_idx,
    output logic [N-1:0]    irq_pending,
    output logic            irq_lost
);
    import irq_pkg::*;

    logic [N-1:0]    req_q;
    logic [N-1:0]    pending_q, pending_d;
    logic [0:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            lost_q, lost_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    clr;
    logic [N-1:0]    eligible;
    logic [IDXW-1:0] enc_idx;
    logic            enc_any;
    logic            accept;

    assign accept = (state_q == ST_OFFER) && irq_ready;
    assign rise   = req_in & ~req_q;

`ifdef IRQ_MASK_EN
    assign eligible = pending_q & irq_mask;
`else
    assign eligible = pending_q;
`endif

    irq_prio_enc #(
        .N    (N),
        .IDXW (IDXW)
    ) u_prio_enc (
        .vec_i (eligible),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    always_comb begin
        clr = '0;
        clr[idx_q] = accept;
        // Set is OR'd after the clear so a coincident rise keeps the bit pending.
        pending_d = (pending_q & ~clr) | rise;
        lost_d    = |(rise & pending_q & ~clr);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d = ST_OFFER;
                    idx_d   = enc_idx;
                end
            end
            ST_OFFER: begin
                if (irq_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            lost_q    <= 1'b0;
        end else begin
            req_q     <= req_in;
            pending_q <= pending_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            lost_q    <= lost_d;
        end
    end

    assign irq_valid   = (state_q == ST_OFFER);
    assign irq_idx     = idx_q;
    assign irq_pending = pending_q;
    assign irq_lost    = lost_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl; accepted indices are checked against a queue of expectations.
module tb_irq_pending_ctrl;
    localparam int unsigned N    = 8;
    localparam int unsigned IDXW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_in;
    logic            irq_ready;
    logic            irq_valid;
    logic [IDXW-1:0] irq_idx;
    logic [N-1:0]    irq_pending;
    logic            irq_lost;
`ifdef IRQ_MASK_EN
    logic [N-1:0]    irq_mask;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [IDXW-1:0] exp_q[$];

    irq_pending_ctrl #(
        .N    (N),
        .IDXW (IDXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .irq_ready   (irq_ready),
`ifdef IRQ_MASK_EN
        .irq_mask    (irq_mask),
`endif
        .irq_valid   (irq_valid),
        .irq_idx     (irq_idx),
        .irq_pending (irq_pending),
        .irq_lost    (irq_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_in    = '0;
        irq_ready = 1'b0;
`ifdef IRQ_MASK_EN
        irq_mask  = '1;
`endif

        fork
            // Scoreboard monitor: every accepted offer must match the oldest expectation.
            forever begin
                @(negedge clk);
                if (rst_n && irq_valid && irq_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_accept", 32'(irq_idx), 32'hFFFF_FFFF);
                    end else begin
                        check("accept_idx", 32'(irq_idx), 32'(exp_q.pop_front()));
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "timeout");
            end
        join_none

        tick(3);
        check("rst_valid",   32'(irq_valid),   32'h0);
        check("rst_idx",     32'(irq_idx),     32'h0);
        check("rst_pending", 32'(irq_pending), 32'h0);
        check("rst_lost",    32'(irq_lost),    32'h0);
        rst_n = 1'b1;
        tick(2);

        // Single event, held high: one offer only.
        irq_ready = 1'b1;
        exp_q.push_back(3'd2);
        req_in = 8'h04;
        tick();
        check("single_pend", 32'(irq_pending), 32'h04);
        check("single_nov",  32'(irq_valid),   32'h0);
        tick();
        check("single_val",  32'(irq_valid),   32'h1);
        check("single_idx",  32'(irq_idx),     32'h2);
        tick();
        check("single_clr",  32'(irq_pending), 32'h00);
        check("single_drop", 32'(irq_valid),   32'h0);
        tick(4);
        check("single_noreoffer", 32'(irq_valid), 32'h0);
        req_in = '0;
        tick();

        // Priority: 0x81 offers 7, bubble, then 0.
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        req_in = 8'h81;
        tick(2);
        check("prio_idx7",   32'(irq_idx),     32'h7);
        tick();
        check("prio_bubble", 32'(irq_valid),   32'h0);
        check("prio_pend",   32'(irq_pending), 32'h01);
        tick();
        check("prio_val0",   32'(irq_valid),   32'h1);
        check("prio_idx0",   32'(irq_idx),     32'h0);
        tick();
        check("prio_clr",    32'(irq_pending), 32'h00);
        req_in = '0;
        tick();

        // Backpressure: offer of 2 holds while bit 6 arrives.
        irq_ready = 1'b0;
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd6);
        req_in = 8'h04;
        tick(2);
        check("bp_idx2", 32'(irq_idx), 32'h2);
        req_in = 8'h44;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_idx", 32'(irq_idx),   32'h2);
            check("bp_hold_val", 32'(irq_valid), 32'h1);
        end
        check("bp_pend", 32'(irq_pending), 32'h44);
        irq_ready = 1'b1;
        tick();
        check("bp_bubble", 32'(irq_valid), 32'h0);
        tick();
        check("bp_idx6",   32'(irq_idx),   32'h6);
        check("bp_val6",   32'(irq_valid), 32'h1);
        tick();
        check("bp_clr",    32'(irq_pending), 32'h00);
        req_in = '0;
        tick();

        // Lost event: bit 5 pending behind an offer of 7, re-rises.
        irq_ready = 1'b0;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd5);
        req_in = 8'h80;
        tick(2);
        req_in = 8'hA0;
        tick();
        check("lost_none", 32'(irq_lost), 32'h0);
        req_in = 8'h80;
        tick();
        req_in = 8'hA0;
        tick();
        check("lost_pulse", 32'(irq_lost),       32'h1);
        check("lost_pend5", 32'(irq_pending[5]), 32'h1);
        tick();
        check("lost_end",   32'(irq_lost),       32'h0);
        irq_ready = 1'b1;
        tick(2);
        check("lost_idx5",  32'(irq_idx),   32'h5);
        check("lost_val5",  32'(irq_valid), 32'h1);
        tick();
        check("lost_clr",   32'(irq_pending), 32'h00);
        req_in = '0;
        tick();

        // Set wins: bit 3 re-rises on the accept edge of idx 3.
        irq_ready = 1'b0;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        req_in = 8'h08;
        tick(2);
        check("sw_idx3", 32'(irq_idx), 32'h3);
        req_in = '0;
        tick();
        req_in = 8'h08;
        irq_ready = 1'b1;
        tick();
        check("sw_pend",  32'(irq_pending), 32'h08);
        check("sw_lost",  32'(irq_lost),    32'h0);
        check("sw_bub",   32'(irq_valid),   32'h0);
        tick();
        check("sw_reoff", 32'(irq_valid),   32'h1);
        check("sw_idx",   32'(irq_idx),     32'h3);
        tick();
        check("sw_clr",   32'(irq_pending), 32'h00);
        req_in = '0;
        tick(3);
        check("idle_ready_ign", 32'(irq_valid), 32'h0);
        check("idle_idx_hold",  32'(irq_idx),   32'h3);

        // Reset mid-offer drops the offer; held line re-fires after release.
        irq_ready = 1'b0;
        req_in = 8'h10;
        tick(2);
        check("ro_val", 32'(irq_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        check("ro_valid",   32'(irq_valid),   32'h0);
        check("ro_idx",     32'(irq_idx),     32'h0);
        check("ro_pending", 32'(irq_pending), 32'h0);
        check("ro_lost",    32'(irq_lost),    32'h0);
        exp_q.push_back(3'd4);
        rst_n = 1'b1;
        tick();
        check("ro_refire", 32'(irq_pending), 32'h10);
        irq_ready = 1'b1;
        tick();
        check("ro_idx4", 32'(irq_idx), 32'h4);
        tick();
        req_in = '0;
        tick();

`ifdef IRQ_MASK_EN
        irq_mask = 8'h7F;
        req_in = 8'h80;
        tick(4);
        check("mask_pend", 32'(irq_pending), 32'h80);
        check("mask_nov",  32'(irq_valid),   32'h0);
        exp_q.push_back(3'd7);
        irq_mask = 8'hFF;
        tick();
        check("mask_val", 32'(irq_valid), 32'h1);
        tick();
        req_in = '0;
        tick();
`endif

        tick(2);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
